// File: rtl/demux4_deser.sv
// Serial-to-nibble deserializer: steers accepted 1-bit samples into four lanes
// (round-robin or addressed) and emits the reassembled word once all lanes are fresh.
module demux4_deser (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  input  logic       in_valid,
  input  logic       mode,
  input  logic [1:0] select,
  input  logic       clear,
  output logic [3:0] lanes,
  output logic [3:0] lane_valid,
  output logic [3:0] word,
  output logic       word_valid,
  output logic       overrun
);

  logic [3:0] lanes_q, lanes_d;
  logic [3:0] lane_valid_q, lane_valid_d;
  logic [3:0] word_q, word_d;
  logic       word_valid_q, word_valid_d;
  logic       overrun_q, overrun_d;
  logic [1:0] ptr_q, ptr_d;
  logic       mode_q;

  logic       mode_change;
  logic       flush;
  logic       acc;
  logic       done;
  logic [1:0] tgt;
  logic [3:0] tgt_oh;

  always_comb begin
    mode_change  = (mode != mode_q);
    flush        = clear | mode_change;
    acc          = in_valid & ~flush;
    tgt          = mode ? select : ptr_q;
    tgt_oh       = 4'b0001 << tgt;
    done         = acc && ((lane_valid_q | tgt_oh) == 4'b1111);

    lanes_d      = lanes_q;
    lane_valid_d = lane_valid_q;
    word_d       = word_q;
    word_valid_d = done;
    overrun_d    = overrun_q;
    ptr_d        = ptr_q;

    if (acc) begin
      lanes_d[tgt] = in;
    end

    // A mode switch flushes like clear but must not hide an earlier overrun.
    if (flush) begin
      lane_valid_d = 4'b0000;
      ptr_d        = 2'd0;
      if (clear) begin
        overrun_d = 1'b0;
      end
    end else if (acc) begin
      lane_valid_d = done ? 4'b0000 : (lane_valid_q | tgt_oh);
      if (!mode) begin
        ptr_d = ptr_q + 2'd1;
      end else if (lane_valid_q[select]) begin
        overrun_d = 1'b1;
      end
      if (done) begin
        word_d = lanes_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lanes_q      <= 4'b0000;
      lane_valid_q <= 4'b0000;
      word_q       <= 4'b0000;
      word_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      ptr_q        <= 2'd0;
      mode_q       <= 1'b0;
    end else begin
      lanes_q      <= lanes_d;
      lane_valid_q <= lane_valid_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      overrun_q    <= overrun_d;
      ptr_q        <= ptr_d;
      mode_q       <= mode;
    end
  end

  assign lanes      = lanes_q;
  assign lane_valid = lane_valid_q;
  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign overrun    = overrun_q;

endmodule
